mem_port_arbiter: RTL and testbench

Sequential arbiter that shares the single external memory port between the instruction-fetch requester (F stage, read-only) and the data requester (M stage, load/store). It sits between the pipeline and the memory. It registers one access at a time and drives the memory handshake. It returns read data with a one-cycle ready pulse, and the pipeline derives its F/M stalls from that pulse. Arbitration alternates between the two requesters when both are pending, so neither can starve.

---
 rtl/mem_port_arbiter.sv | 84 ++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, alternating on contention
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  input  logic [DATA_W/8-1:0] data_wstrb,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_n;
  logic last_d, last_d_n;
  logic mem_req_n, mem_wr_n, inst_ready_n, data_ready_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, inst_rdata_n, data_rdata_n;
  logic [DATA_W/8-1:0] mem_wstrb_n;
  logic inst_elig, data_elig, grant_d, grant_i, grant, store, done;
  assign inst_elig = inst_req & ~inst_ready;
  assign data_elig = data_req & ~data_ready;
  assign grant_d = (state == IDLE) & data_elig & (~inst_elig | ~last_d);
  assign grant_i = (state == IDLE) & inst_elig & ~grant_d;
  assign grant = grant_d | grant_i;
  assign store = grant_d & data_wr;
  assign done = (state != IDLE) & mem_ready;
  // next state, latched access on grant, completion data and ready pulses
  always_comb begin
    state_n = grant_d ? BUSY_D : grant_i ? BUSY_I : done ? IDLE : state;
    last_d_n = grant ? grant_d : last_d;
    mem_req_n = grant | (mem_req & ~done);
    mem_wr_n = grant ? store : mem_wr & ~done;
    mem_addr_n = grant_d ? data_addr : grant_i ? inst_addr : mem_addr;
    mem_wdata_n = store ? data_wdata : grant ? '0 : mem_wdata;
    mem_wstrb_n = store ? data_wstrb : (grant | done) ? '0 : mem_wstrb;
    inst_ready_n = done & (state == BUSY_I);
    data_ready_n = done & (state == BUSY_D);
    inst_rdata_n = inst_ready_n ? mem_rdata : inst_rdata;
    data_rdata_n = data_ready_n ? mem_rdata : data_rdata;
  end
  // state and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_d <= 1'b0;
      mem_req <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state <= state_n;
      last_d <= last_d_n;
      mem_req <= mem_req_n;
      mem_wr <= mem_wr_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      mem_wstrb <= mem_wstrb_n;
      inst_ready <= inst_ready_n;
      data_ready <= data_ready_n;
      inst_rdata <= inst_rdata_n;
      data_rdata <= data_rdata_n;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 0;
  logic rst, inst_req, data_req, data_wr, mem_ready;
  logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0] data_wstrb;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  logic inst_ready, data_ready, mem_req, mem_wr;
  logic [3:0] mem_wstrb;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem_model [logic [31:0]];
  bit m_busy, m_cur_d, m_last_d, m_done, m_wr;
  logic [31:0] m_addr, m_wdata, m_resp, exp_irdata, exp_drdata;
  logic [3:0] m_wstrb;
  int cnt, lat;
  bit auto_resp, agent_on, reissue_i, reissue_d, prev_req;
  logic [5:0] gbits;
  int ngrants, n, k;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ready(inst_ready),
    .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_rdata(data_rdata), .data_ready(data_ready),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a == 32'hBFC00000) ? 32'h24080001 : a ^ 32'hA5A55A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_data();
    data_wr = 1'($urandom);
    data_addr = 32'h80000000 | ($urandom & 32'h3C);
    data_wdata = $urandom;
    data_wstrb = 4'($urandom);
  endtask

  // before the edge: memory answers the outstanding access, or the model arbitrates an idle port
  task automatic arb_eval();
    bit ie, de, gd;
    if (rst) return;
    if (m_busy) begin
      if (auto_resp) begin
        if (cnt == 0) begin
          m_resp = m_wr ? $urandom : rd(m_addr);
          mem_ready = 1;
          mem_rdata = m_resp;
        end else begin
          cnt--;
          mem_rdata = $urandom;
        end
      end
    end else begin
      ie = inst_req && !(m_done && !m_cur_d);
      de = data_req && !(m_done && m_cur_d);
      if (ie || de) begin
        gd = de && (!ie || !m_last_d);
        m_cur_d = gd;
        m_last_d = gd;
        m_busy = 1;
        m_addr = gd ? data_addr : inst_addr;
        m_wr = gd && data_wr;
        m_wdata = m_wr ? data_wdata : 32'h0;
        m_wstrb = m_wr ? data_wstrb : 4'h0;
        cnt = lat;
      end
    end
  endtask

  // one clock: arbitrate, advance the model past the edge, compare every output, then requesters react
  task automatic cyc();
    logic [31:0] w;
    arb_eval();
    @(posedge clk);
    #1;
    m_done = 0;
    if (rst) begin
      m_busy = 0;
      m_last_d = 0;
      exp_irdata = 0;
      exp_drdata = 0;
    end else if (mem_ready && m_busy) begin
      m_busy = 0;
      m_done = 1;
      if (m_wr) begin
        w = rd(m_addr);
        for (int b = 0; b < 4; b++) if (m_wstrb[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
        mem_model[m_addr] = w;
      end
      if (m_cur_d) exp_drdata = m_resp;
      else exp_irdata = m_resp;
    end
    mem_ready = 0;
    chk("mem_req", mem_req, m_busy);
    chk("inst_ready", inst_ready, m_done && !m_cur_d);
    chk("data_ready", data_ready, m_done && m_cur_d);
    chk("inst_rdata", inst_rdata, exp_irdata);
    chk("data_rdata", data_rdata, exp_drdata);
    if (m_busy) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wr", mem_wr, m_wr);
      chk("mem_wstrb", mem_wstrb, m_wstrb);
      if (m_wr) chk("mem_wdata", mem_wdata, m_wdata);
    end else begin
      chk("mem_wr_idle", mem_wr, 0);
      chk("mem_wstrb_idle", mem_wstrb, 0);
    end
    if (mem_req && !prev_req) begin
      gbits = {gbits[4:0], mem_addr[31]};
      ngrants++;
    end
    prev_req = mem_req;
    if (agent_on && m_done && !m_cur_d) begin
      if (reissue_i) inst_addr = inst_addr + 4;
      else inst_req = 0;
    end
    if (agent_on && m_done && m_cur_d) begin
      if (reissue_d) new_data();
      else data_req = 0;
    end
  endtask

  task automatic wait_ready(input bit d, input string tag);
    int t = 0;
    while (!(d ? data_ready : inst_ready) && t < 200) begin
      cyc();
      t++;
    end
    chk({tag, "_timeout"}, t < 200, 1);
  endtask

  initial begin
    rst = 1; inst_req = 0; data_req = 0; data_wr = 0; mem_ready = 0; mem_rdata = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0; data_wstrb = 0;
    auto_resp = 1; agent_on = 0; reissue_i = 0; reissue_d = 0; lat = 0; prev_req = 0;
    gbits = 0; ngrants = 0;
    cyc();
    cyc();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_inst_ready", inst_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);
    rst = 0;
    agent_on = 1;
    lat = 2; inst_addr = 32'hBFC00000; inst_req = 1;
    n = 0; k = 0;
    while (!inst_ready && k < 50) begin
      cyc();
      if (mem_req) n++;
      k++;
    end
    chk("fetch_req_cycles", n, 3);
    chk("fetch_rdata", inst_rdata, 32'h24080001);
    cyc();
    chk("fetch_pulse", inst_ready, 0);
    chk("fetch_hold", inst_rdata, 32'h24080001);
    lat = 0; data_wr = 1; data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF; data_wstrb = 4'b0011; data_req = 1;
    cyc();
    chk("store_wr", mem_wr, 1);
    chk("store_wstrb", mem_wstrb, 4'b0011);
    chk("store_early", data_ready, 0);
    cyc();
    chk("store_ready", data_ready, 1);
    chk("store_wr_off", mem_wr, 0);
    cyc();
    lat = 1; data_wr = 0; data_req = 1;
    wait_ready(1, "load");
    chk("load_merge", data_rdata, 32'h25A5BEEF);
    cyc();
    rst = 1;
    cyc();
    rst = 0; gbits = 0; ngrants = 0;
    lat = $urandom_range(0, 3);
    inst_addr = 32'h100; inst_req = 1; new_data(); data_req = 1; reissue_i = 1; reissue_d = 1;
    k = 0;
    while (ngrants < 6 && k < 200) begin
      cyc();
      k++;
    end
    chk("contention_order", gbits, 6'b101010);
    reissue_i = 0; reissue_d = 0;
    k = 0;
    while ((inst_req || data_req || m_busy) && k < 200) begin
      cyc();
      k++;
    end
    chk("contention_drain", k < 200, 1);
    cyc();
    agent_on = 0; lat = 0; inst_addr = 32'h300; inst_req = 1;
    wait_ready(0, "stale1");
    cyc();
    chk("stale_masked", mem_req, 0);
    cyc();
    chk("stale_regrant", mem_req, 1);
    wait_ready(0, "stale2");
    cyc();
    chk("stale_masked2", mem_req, 0);
    inst_req = 0;
    cyc();
    chk("stale_dropped", mem_req, 0);
    agent_on = 1;
    auto_resp = 0; data_wr = 0; data_addr = 32'h80000030; data_req = 1;
    cyc();
    chk("rst_busy1", mem_req, 1);
    cyc();
    rst = 1; data_req = 0;
    cyc();
    rst = 0; mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    chk("abort_mem_req", mem_req, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_mem_wdata", mem_wdata, 0);
    chk("abort_data_ready", data_ready, 0);
    repeat (4) begin
      cyc();
      chk("late_ready_ignored", data_ready, 0);
      chk("abort_idle", mem_req, 0);
    end
    auto_resp = 1;
    lat = 20; data_wr = 0; data_addr = 32'h80000040; data_req = 1;
    cyc();
    inst_addr = 32'h200; inst_req = 1;
    k = 0;
    while (!data_ready && k < 60) begin
      chk("stall_addr", mem_addr, 32'h80000040);
      chk("stall_wstrb", mem_wstrb, 0);
      chk("stall_inst_ready", inst_ready, 0);
      cyc();
      k++;
    end
    chk("stall_cycles", k, 21);
    chk("stall_gap", mem_req, 0);
    cyc();
    chk("stall_fetch_req", mem_req, 1);
    chk("stall_fetch_addr", mem_addr, 32'h200);
    wait_ready(0, "stall_fetch");
    repeat (3000) begin
      lat = $urandom_range(0, 4);
      reissue_i = 1'($urandom);
      reissue_d = 1'($urandom);
      if (!inst_req && $urandom_range(0, 3) == 0) begin
        inst_addr = 32'(4 * $urandom_range(0, 1023));
        inst_req = 1;
      end
      if (!data_req && $urandom_range(0, 3) == 0) begin
        new_data();
        data_req = 1;
      end
      cyc();
    end
    reissue_i = 0; reissue_d = 0;
    k = 0;
    while ((inst_req || data_req || m_busy) && k < 300) begin
      cyc();
      k++;
    end
    chk("final_drain", k < 300, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
